// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense unit: FSM states,
// one-hot coin encodings with their values, and the restock reload table.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EVAL   = 3'd1,
    ST_VEND   = 3'd2,
    ST_CHANGE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [2:0] COIN_5  = 3'b001;
  localparam logic [2:0] COIN_10 = 3'b010;
  localparam logic [2:0] COIN_20 = 3'b100;

  localparam int unsigned COIN_VAL_5  = 5;
  localparam int unsigned COIN_VAL_10 = 10;
  localparam int unsigned COIN_VAL_20 = 20;

  // Reload values for items 0..3.
  localparam int unsigned STOCK_INIT [4] = '{7, 5, 3, 0};

  // Greedy coin choice for a remaining amount; 0 when nothing can be paid.
  function automatic logic [2:0] coin_pick(input int unsigned amt);
    if (amt >= COIN_VAL_20)      return COIN_20;
    else if (amt >= COIN_VAL_10) return COIN_10;
    else if (amt >= COIN_VAL_5)  return COIN_5;
    else                         return 3'b000;
  endfunction

  function automatic int unsigned coin_value(input logic [2:0] coin);
    case (coin)
      COIN_20: return COIN_VAL_20;
      COIN_10: return COIN_VAL_10;
      COIN_5:  return COIN_VAL_5;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/vend_stock.sv
// Four saturating per-item stock counters with reload and single-item
// decrement. Compiled only when VEND_STOCK_EN is defined.
`ifdef VEND_STOCK_EN
module vend_stock
  import vend_pkg::*;
#(
  parameter int STOCK_W = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reload,
  input  logic       dec,
  input  logic [1:0] dec_idx,
  output logic [3:0] out_of_stock
);

  logic [STOCK_W-1:0] stock [4];

  // NOTE: this array is reset explicitly because its contents are
  // architectural state (the reload values), not scratch storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT[i]);
    end else if (reload) begin
      for (int i = 0; i < 4; i++) stock[i] <= STOCK_W'(STOCK_INIT[i]);
    end else if (dec && (stock[dec_idx] != '0)) begin
      stock[dec_idx] <= stock[dec_idx] - STOCK_W'(1);
    end
  end

  // NOTE: default first so every path assigns and no latch is inferred.
  always_comb begin
    out_of_stock = '0;
    for (int i = 0; i < 4; i++) out_of_stock[i] = (stock[i] == '0);
  end

endmodule
`endif

// File: rtl/vend_dispenser.sv
// Dispense unit: decides vend vs refund, hands out one item and greedy
// 20/10/5 change. Stock tracking is present only with VEND_STOCK_EN.
module vend_dispenser
  import vend_pkg::*;
#(
  parameter int MONEY_W = 8,
  parameter int STOCK_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               end_trans,
  input  logic [MONEY_W-1:0] sum_money,
  input  logic [MONEY_W-1:0] price,
  input  logic [1:0]         item_select,
  input  logic               restock,
  output logic               item_valid,
  output logic [1:0]         item_out,
  input  logic               item_ack,
  output logic               coin_valid,
  output logic [2:0]         coin_out,
  input  logic               coin_ack,
  output logic               busy,
  output logic               tx_done,
  output logic               refunded,
  output logic [2:0]         residue,
  output logic [3:0]         out_of_stock
);

  state_e             state;
  logic [MONEY_W-1:0] sum_q;
  logic [MONEY_W-1:0] price_q;
  logic [MONEY_W-1:0] remainder;
  logic [1:0]         item_q;
  logic               item_empty;
  logic               change_left;
  logic [2:0]         coin_sel;

  assign change_left = (remainder >= MONEY_W'(COIN_VAL_5));
  assign coin_sel    = coin_pick(32'(remainder));

  assign busy       = (state != ST_IDLE);
  assign tx_done    = (state == ST_DONE);
  assign item_valid = (state == ST_VEND);
  assign item_out   = item_valid ? item_q : 2'd0;
  assign coin_valid = (state == ST_CHANGE) && change_left;
  assign coin_out   = coin_valid ? coin_sel : 3'b000;

`ifdef VEND_STOCK_EN
  vend_stock #(.STOCK_W(STOCK_W)) u_stock (
    .clk          (clk),
    .reset        (reset),
    .reload       ((state == ST_IDLE) && restock && !end_trans),
    .dec          ((state == ST_VEND) && item_ack),
    .dec_idx      (item_q),
    .out_of_stock (out_of_stock)
  );
  assign item_empty = out_of_stock[item_q];
`else
  logic unused_restock;
  assign unused_restock = restock;
  assign out_of_stock   = 4'b0000;
  assign item_empty     = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sum_q     <= '0;
      price_q   <= '0;
      remainder <= '0;
      item_q    <= 2'd0;
      refunded  <= 1'b0;
      residue   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (end_trans) begin
            sum_q   <= sum_money;
            price_q <= price;
            item_q  <= item_select;
            state   <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          // Subtract only after the compare has passed, so no underflow.
          if ((sum_q >= price_q) && !item_empty) begin
            remainder <= sum_q - price_q;
            state     <= ST_VEND;
          end else begin
            remainder <= sum_q;
            refunded  <= 1'b1;
            state     <= ST_CHANGE;
          end
        end
        ST_VEND: begin
          if (item_ack) state <= ST_CHANGE;
        end
        ST_CHANGE: begin
          if (!change_left) begin
            residue <= remainder[2:0];
            state   <= ST_DONE;
          end else if (coin_ack) begin
            remainder <= remainder - MONEY_W'(coin_value(coin_sel));
          end
        end
        ST_DONE: begin
          refunded <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_dispenser.sv
// Scoreboard bench for vend_dispenser: stimulus pushes expected item, coin
// and completion events; a negedge monitor pops and compares them.
module tb_vend_dispenser;

`ifdef VEND_STOCK_EN
  localparam bit STOCK_EN = 1'b1;
`else
  localparam bit STOCK_EN = 1'b0;
`endif

  localparam int EV_ITEM = 0;
  localparam int EV_COIN = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       end_trans = 1'b0;
  logic [7:0] sum_money = '0;
  logic [7:0] price = '0;
  logic [1:0] item_select = '0;
  logic       restock = 1'b0;
  logic       item_valid;
  logic [1:0] item_out;
  logic       item_ack = 1'b0;
  logic       coin_valid;
  logic [2:0] coin_out;
  logic       coin_ack = 1'b0;
  logic       busy;
  logic       tx_done;
  logic       refunded;
  logic [2:0] residue;
  logic [3:0] out_of_stock;

  vend_dispenser #(.MONEY_W(8), .STOCK_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .end_trans    (end_trans),
    .sum_money    (sum_money),
    .price        (price),
    .item_select  (item_select),
    .restock      (restock),
    .item_valid   (item_valid),
    .item_out     (item_out),
    .item_ack     (item_ack),
    .coin_valid   (coin_valid),
    .coin_out     (coin_out),
    .coin_ack     (coin_ack),
    .busy         (busy),
    .tx_done      (tx_done),
    .refunded     (refunded),
    .residue      (residue),
    .out_of_stock (out_of_stock)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0 = 0;
  int   item_cyc = 0;
  int   done_cyc = 0;
  int   done_cnt = 0;
  int   coin_hs = 0;
  int   coin_delay = 0;
  int   wait_cnt = 0;
  bit   stray_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic mon_ev(input string nm, input int kind, input int val, input bit pop);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s unexpected: got value %0d, no event expected (cycle %0d)", nm, val, cyc);
    end else begin
      check({nm, "_kind"}, kind, exp_q[0].kind);
      check(nm, val, exp_q[0].val);
      if (pop) void'(exp_q.pop_front());
    end
  endtask

  // Ack responder: item acked at once, coins after coin_delay wait cycles.
  always @(posedge clk) begin
    #1;
    item_ack = item_valid | stray_ack;
    if (coin_valid) begin
      if (wait_cnt >= coin_delay) begin
        coin_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        coin_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      coin_ack = stray_ack;
      wait_cnt = 0;
    end
  end

  // Monitor: every presented valid is compared against the queue front.
  always @(negedge clk) begin
    if (!reset) begin
      if (item_valid) begin
        mon_ev("item", EV_ITEM, int'(item_out), item_ack);
        if (item_ack) item_cyc = cyc;
      end
      if (coin_valid) begin
        mon_ev("coin", EV_COIN, int'(coin_out), coin_ack);
        if (coin_ack) coin_hs++;
      end
      if (tx_done) begin
        mon_ev("done", EV_DONE, int'({refunded, residue}), 1'b1);
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  task automatic run_trans(input int s, input int p, input int it, input bit rs);
    int start;
    @(posedge clk);
    #1;
    sum_money   = 8'(s);
    price       = 8'(p);
    item_select = 2'(it);
    restock     = rs;
    end_trans   = 1'b1;
    t0          = cyc;
    start       = done_cnt;
    @(posedge clk);
    #1;
    end_trans = 1'b0;
    restock   = 1'b0;
    for (int i = 0; i < 300 && done_cnt == start; i++) @(posedge clk);
    #1;
    check("tx_done_seen", done_cnt - start, 1);
    check("queue_drained", exp_q.size(), 0);
    check("idle_after_tx", int'(busy), 0);
  endtask

  task automatic check_idle_outputs(input string nm, input logic [3:0] oos_exp);
    check({nm, "_busy"}, int'(busy), 0);
    check({nm, "_item_valid"}, int'(item_valid), 0);
    check({nm, "_coin_valid"}, int'(coin_valid), 0);
    check({nm, "_tx_done"}, int'(tx_done), 0);
    check({nm, "_refunded"}, int'(refunded), 0);
    check({nm, "_coin_out"}, int'(coin_out), 0);
    check({nm, "_item_out"}, int'(item_out), 0);
    check({nm, "_oos"}, int'(out_of_stock), int'(oos_exp));
  endtask

  initial begin
    logic [3:0] oos_init;
    logic [3:0] oos_item2_empty;
    int         start;
    oos_init        = STOCK_EN ? 4'b1000 : 4'b0000;
    oos_item2_empty = STOCK_EN ? 4'b1100 : 4'b0000;

    #2;
    check_idle_outputs("reset", oos_init);
    check("reset_residue", int'(residue), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // item 0, 31 paid for 15: change 10 + 5, residue 1; stray acks ignored.
    stray_ack = 1'b1;
    push(EV_ITEM, 0);
    push(EV_COIN, 3'b010);
    push(EV_COIN, 3'b001);
    push(EV_DONE, 4'b0001);
    run_trans(31, 15, 0, 1'b0);
    check("item_latency", item_cyc - t0, 2);
    check("oos_after_item0", int'(out_of_stock), int'(oos_init));

    // item 3 is empty (and 20 < 21): refund a single 20 coin; stray acks on.
    push(EV_COIN, 3'b100);
    push(EV_DONE, 4'b1000);
    run_trans(20, 21, 3, 1'b0);
    stray_ack = 1'b0;

    // Exact money: no coins, tx_done 4 cycles after end_trans.
    push(EV_ITEM, 2);
    push(EV_DONE, 4'b0000);
    run_trans(7, 7, 2, 1'b0);
    check("min_latency", done_cyc - t0, 4);

    // Short money: refund 7 as one 5 coin, residue 2.
    push(EV_COIN, 3'b001);
    push(EV_DONE, 4'b1010);
    run_trans(7, 31, 1, 1'b0);

    // Hopper stalls 5 cycles on a 20 coin; monitor checks it every cycle.
    coin_delay = 5;
    start = coin_hs;
    push(EV_ITEM, 1);
    push(EV_COIN, 3'b100);
    push(EV_DONE, 4'b0000);
    run_trans(25, 5, 1, 1'b0);
    check("stall_one_coin", coin_hs - start, 1);
    coin_delay = 0;

    // Drain item 2 (stock 2 -> 0).
    for (int k = 0; k < 2; k++) begin
      push(EV_ITEM, 2);
      push(EV_DONE, 4'b0000);
      run_trans(5, 5, 2, 1'b0);
    end
    check("oos_item2_empty", int'(out_of_stock), int'(oos_item2_empty));

    // Empty item 2 with restock in the same cycle: end_trans wins.
    if (STOCK_EN) begin
      push(EV_COIN, 3'b010);
      push(EV_DONE, 4'b1010);
    end else begin
      push(EV_ITEM, 2);
      push(EV_COIN, 3'b001);
      push(EV_DONE, 4'b0010);
    end
    run_trans(12, 5, 2, 1'b1);
    check("restock_dropped", int'(out_of_stock), int'(oos_item2_empty));

    @(posedge clk);
    #1;
    restock = 1'b1;
    @(posedge clk);
    #1;
    restock = 1'b0;
    check("restock_reload", int'(out_of_stock), int'(oos_init));

    // Reset in CHANGE after the first of 20+20+5.
    push(EV_ITEM, 0);
    push(EV_COIN, 3'b100);
    @(posedge clk);
    #1;
    sum_money   = 8'd45;
    price       = 8'd0;
    item_select = 2'd0;
    end_trans   = 1'b1;
    start       = coin_hs;
    @(posedge clk);
    #1;
    end_trans = 1'b0;
    for (int i = 0; i < 100 && coin_hs == start; i++) @(posedge clk);
    #1;
    check("first_coin_seen", coin_hs - start, 1);
    check("busy_mid_change", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("midreset", oos_init);
    check("midreset_queue", exp_q.size(), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    restock = 1'b1;
    @(posedge clk);
    #1;
    restock = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs("post_restock", oos_init);

    repeat (3) @(posedge clk);
    check("final_queue", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
